// File: rtl/bcd_clock_timer.sv
// bcd_clock_timer: 12-hour BCD hh:mm:ss clock loaded and started by the Control
// stage. It decodes Control's state code into clear, load and start actions,
// keeps a per-second prescaler, and emits secondTick and hourWrap pulses.
//
// Invalid digits: a minute or second digit at or above its maximum behaves as
// that maximum, so it wraps on the next carry into it. In the hour field any
// nonzero HH behaves as 1. Hours 13..1F are read like 24-hour values and fold
// into the 12-hour range, so 1F (25) is followed by 02.
module bcd_clock_timer #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  state,
    input  logic [23:0] controlledToggleSwitchBits,
    output logic [23:0] timeDigits,
    output logic        running,
    output logic        secondTick,
    output logic        hourWrap
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] TC = PW'(TICKS_PER_SEC - 1);

    localparam logic [3:0] ST_RESET = 4'd0;
    localparam logic [3:0] ST_SET   = 4'd1;
    localparam logic [3:0] ST_START = 4'd3;

    logic [23:0]   time_q, time_d, time_adv;
    logic          run_q, run_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          wrap_adv;

    logic [3:0] ls, hs, lm, hm, lh, hh;
    logic [3:0] n_ls, n_hs, n_lm, n_hm, n_lh, n_hh;

    assign ls = time_q[3:0];
    assign hs = time_q[7:4];
    assign lm = time_q[11:8];
    assign hm = time_q[15:12];
    assign lh = time_q[19:16];
    assign hh = time_q[23:20];

    assign time_adv = {n_hh, n_lh, n_hm, n_lm, n_hs, n_ls};

    // Time one second after time_q, rippling carries from LS upward.
    always_comb begin
        n_ls     = ls;
        n_hs     = hs;
        n_lm     = lm;
        n_hm     = hm;
        n_lh     = lh;
        n_hh     = hh;
        wrap_adv = 1'b0;
        if (ls < 4'd9) begin
            n_ls = ls + 4'd1;
        end else begin
            n_ls = 4'd0;
            if (hs < 4'd5) begin
                n_hs = hs + 4'd1;
            end else begin
                n_hs = 4'd0;
                if (lm < 4'd9) begin
                    n_lm = lm + 4'd1;
                end else begin
                    n_lm = 4'd0;
                    if (hm < 4'd5) begin
                        n_hm = hm + 4'd1;
                    end else begin
                        n_hm = 4'd0;
                        if (hh == 4'd0) begin
                            if (lh >= 4'd9) begin
                                n_hh = 4'd1;
                                n_lh = 4'd0;
                            end else begin
                                n_hh = 4'd0;
                                n_lh = lh + 4'd1;
                            end
                        end else begin
                            case (lh)
                                4'd0: begin n_hh = 4'd1; n_lh = 4'd1; end
                                4'd1: begin n_hh = 4'd1; n_lh = 4'd2; end
                                4'd2: begin
                                    n_hh     = 4'd0;
                                    n_lh     = 4'd1;
                                    wrap_adv = 1'b1;
                                end
                                4'd3, 4'd4, 4'd5, 4'd6,
                                4'd7, 4'd8, 4'd9, 4'd10: begin
                                    n_hh = 4'd0;
                                    n_lh = lh - 4'd1;
                                end
                                4'd11: begin n_hh = 4'd1; n_lh = 4'd0; end
                                4'd12: begin n_hh = 4'd1; n_lh = 4'd1; end
                                4'd13: begin n_hh = 4'd1; n_lh = 4'd2; end
                                4'd14: begin n_hh = 4'd0; n_lh = 4'd1; end
                                default: begin n_hh = 4'd0; n_lh = 4'd2; end
                            endcase
                        end
                    end
                end
            end
        end
    end

    // Control decode: clear beats load beats start beats counting.
    always_comb begin
        time_d  = time_q;
        run_d   = run_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (state == ST_RESET) begin
            time_d  = 24'h000000;
            run_d   = 1'b0;
            presc_d = '0;
        end else if (state == ST_SET) begin
            time_d  = controlledToggleSwitchBits;
            run_d   = 1'b0;
            presc_d = '0;
        end else if (state == ST_START && !run_q) begin
            run_d   = 1'b1;
            presc_d = '0;
        end else if (run_q) begin
            if (presc_q == TC) begin
                presc_d = '0;
                time_d  = time_adv;
                tick_d  = 1'b1;
                wrap_d  = wrap_adv;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_q  <= 24'h000000;
            run_q   <= 1'b0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            time_q  <= time_d;
            run_q   <= run_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign timeDigits = time_q;
    assign running    = run_q;
    assign secondTick = tick_q;
    assign hourWrap   = wrap_q;

endmodule

// File: tb/tb_bcd_clock_timer.sv
// Bench for bcd_clock_timer with a 4-cycle second: directed Control sequences,
// a cycle-level reference model compared at every falling edge, and literal
// expectations at the key points of each sequence.
module tb_bcd_clock_timer;

    localparam int TPS = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  state;
    logic [23:0] sw;
    logic [23:0] timeDigits;
    logic        running;
    logic        secondTick;
    logic        hourWrap;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_clock_timer #(.TICKS_PER_SEC(TPS)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .state                      (state),
        .controlledToggleSwitchBits (sw),
        .timeDigits                 (timeDigits),
        .running                    (running),
        .secondTick                 (secondTick),
        .hourWrap                   (hourWrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: time, run flag, and the cycle at which counting was started.
    logic [23:0] m_time;
    bit          m_run, m_tick, m_wrap;
    int          cyc, m_start;

    function automatic logic [23:0] model_adv(input logic [23:0] t, output bit w);
        int ls, hs, lm, hm, lh, hh, h, nh;
        ls = int'(t[3:0]);   hs = int'(t[7:4]);
        lm = int'(t[11:8]);  hm = int'(t[15:12]);
        lh = int'(t[19:16]); hh = int'(t[23:20]);
        w = 1'b0;
        if (ls < 9) ls++;
        else begin
            ls = 0;
            if (hs < 5) hs++;
            else begin
                hs = 0;
                if (lm < 9) lm++;
                else begin
                    lm = 0;
                    if (hm < 5) hm++;
                    else begin
                        hm = 0;
                        if (hh == 0) nh = ((lh > 9) ? 9 : lh) + 1;
                        else begin
                            h  = 10 + lh;
                            w  = (h == 12);
                            nh = (h % 12) + 1;
                        end
                        hh = nh / 10;
                        lh = nh % 10;
                    end
                end
            end
        end
        return {hh[3:0], lh[3:0], hm[3:0], lm[3:0], hs[3:0], ls[3:0]};
    endfunction

    always @(posedge clk or posedge reset) begin
        bit w;
        if (reset) begin
            m_time = 24'h0; m_run = 0; m_tick = 0; m_wrap = 0;
        end else begin
            cyc++;
            m_tick = 0; m_wrap = 0;
            if (state == 4'd0) begin
                m_time = 24'h0; m_run = 0;
            end else if (state == 4'd1) begin
                m_time = sw; m_run = 0;
            end else if (state == 4'd3 && !m_run) begin
                m_run = 1; m_start = cyc;
            end else if (m_run && ((cyc - m_start) % TPS == 0)) begin
                m_time = model_adv(m_time, w);
                m_tick = 1;
                m_wrap = w;
            end
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if ({timeDigits, running, secondTick, hourWrap} !== {m_time, m_run, m_tick, m_wrap}) begin
            n_bad++;
            $display("FAIL model t=%0t: got time=%h run=%b tick=%b wrap=%b, expected time=%h run=%b tick=%b wrap=%b",
                     $time, timeDigits, running, secondTick, hourWrap, m_time, m_run, m_tick, m_wrap);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply inputs 2 time units after an edge, then wait n edges and settle.
    task automatic drive(input logic [3:0] st, input logic [23:0] v, input int n);
        state = st;
        sw    = v;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic load_start(input logic [23:0] v);
        drive(4'd1, v, 1);
        drive(4'd3, v, 1);
    endtask

    initial begin
        reset = 1'b1;
        state = 4'd4;
        sw    = 24'h0;
        cyc   = 0;
        m_start = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_time", {8'h0, timeDigits}, 32'h0);
        chk("reset_run",  {31'h0, running},   32'h0);
        chk("reset_tick", {31'h0, secondTick}, 32'h0);
        chk("reset_wrap", {31'h0, hourWrap},  32'h0);
        reset = 1'b0;

        // Load while stopped: value appears next cycle, nothing counts.
        drive(4'd1, 24'h123456, 1);
        chk("load_123456", {8'h0, timeDigits}, 32'h123456);
        drive(4'd4, 24'h0, 20);
        chk("hold_123456", {8'h0, timeDigits}, 32'h123456);
        chk("hold_run",    {31'h0, running},   32'h0);

        // Repeated loads: the latest wins.
        drive(4'd1, 24'h111111, 1);
        drive(4'd1, 24'h020304, 1);
        chk("reload", {8'h0, timeDigits}, 32'h020304);

        // 01:59:59 -> 02:00:00 four cycles after start.
        load_start(24'h015959);
        chk("start_run", {31'h0, running}, 32'h1);
        drive(4'd4, 24'h0, 3);
        chk("pre_tick_time", {8'h0, timeDigits}, 32'h015959);
        chk("pre_tick",      {31'h0, secondTick}, 32'h0);
        drive(4'd4, 24'h0, 1);
        chk("adv_020000", {8'h0, timeDigits}, 32'h020000);
        chk("tick_high",  {31'h0, secondTick}, 32'h1);
        drive(4'd4, 24'h0, 1);
        chk("tick_low",   {31'h0, secondTick}, 32'h0);

        // 12:59:59 -> 01:00:00 with hourWrap.
        load_start(24'h125959);
        drive(4'd4, 24'h0, 4);
        chk("adv_010000", {8'h0, timeDigits}, 32'h010000);
        chk("wrap_high",  {31'h0, hourWrap},  32'h1);
        chk("wrap_tick",  {31'h0, secondTick}, 32'h1);
        drive(4'd4, 24'h0, 1);
        chk("wrap_low",   {31'h0, hourWrap},  32'h0);

        // 09:59:59 -> 10:00:00, no hourWrap.
        load_start(24'h095959);
        drive(4'd4, 24'h0, 4);
        chk("adv_100000", {8'h0, timeDigits}, 32'h100000);
        chk("no_wrap",    {31'h0, hourWrap},  32'h0);

        // Clear in a terminal-count cycle wins over the advance.
        drive(4'd4, 24'h0, 3);
        drive(4'd0, 24'h0, 1);
        chk("clr_tc_time", {8'h0, timeDigits}, 32'h0);
        chk("clr_tc_tick", {31'h0, secondTick}, 32'h0);
        chk("clr_tc_run",  {31'h0, running},   32'h0);
        load_start(24'h000059);
        drive(4'd4, 24'h0, 4);
        chk("adv_000100", {8'h0, timeDigits}, 32'h000100);

        // Hour 00 advances to 01.
        load_start(24'h005959);
        drive(4'd4, 24'h0, 4);
        chk("adv_hour00", {8'h0, timeDigits}, 32'h010000);

        // Invalid digits clamp; states 2 and 7 keep running latched.
        load_start(24'h1F7F6F);
        drive(4'd2, 24'h0, 2);
        drive(4'd7, 24'h0, 2);
        chk("adv_invalid", {8'h0, timeDigits}, 32'h020000);
        chk("run_latched", {31'h0, running},   32'h1);
        drive(4'd3, 24'h0, 6);
        drive(4'd4, 24'h0, 6);
        chk("run_still", {31'h0, running}, 32'h1);

        // Asynchronous reset mid-second; no counting until a new start.
        drive(4'd4, 24'h0, 1);
        #1 reset = 1'b1;
        #1;
        chk("async_time", {8'h0, timeDigits}, 32'h0);
        chk("async_run",  {31'h0, running},   32'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        drive(4'd4, 24'h0, 12);
        chk("post_rst_time", {8'h0, timeDigits}, 32'h0);
        chk("post_rst_run",  {31'h0, running},   32'h0);
        drive(4'd3, 24'h0, 1);
        drive(4'd4, 24'h0, 4);
        chk("restart_adv", {8'h0, timeDigits}, 32'h000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
